// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolve unit and its bimodal predictor.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic taken;
    logic mispredict;
    logic illegal;
  } br_flags_t;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

  // funct3 010/011 are the only non-branch encodings
  function automatic logic f3_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/bht_bimodal.sv
// Bimodal table of 2-bit saturating counters: combinational read for fetch,
// synchronous update from resolve.
module bht_bimodal
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] i_rd_pc,
  output logic            o_rd_taken,
  input  logic            i_upd_en,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       r_ctr [BHT_DEPTH];
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_upd_idx;

  // word-aligned PCs: drop the two low bits before indexing
  assign w_rd_idx   = i_rd_pc[IDX_W+1:2];
  assign w_upd_idx  = i_upd_pc[IDX_W+1:2];
  assign o_rd_taken = r_ctr[w_rd_idx][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_ctr[i] <= WNT;
    end else if (i_upd_en) begin
      r_ctr[w_upd_idx] <= sat_update(r_ctr[w_upd_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// One-stage conditional branch resolver with valid/ready handshake, redirect
// PC, mispredict flag, bimodal predictor and resolve statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  fetch_pc_i,
  output logic             fetch_pred_taken_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic [XLEN-1:0]  in_imm_i,
  input  logic [XLEN-1:0]  in_rs1_i,
  input  logic [XLEN-1:0]  in_rs2_i,
  input  logic [2:0]       in_funct3_i,
  input  logic             in_pred_taken_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_taken_o,
  output logic [XLEN-1:0]  out_redirect_pc_o,
  output logic             out_mispredict_o,
  output logic             out_illegal_o,
  output logic [CNT_W-1:0] stat_branches_o,
  output logic [CNT_W-1:0] stat_mispredicts_o
);

  logic             r_valid;
  br_flags_t        r_flags;
  logic [XLEN-1:0]  r_redirect;
  logic [CNT_W-1:0] r_branches;
  logic [CNT_W-1:0] r_mispredicts;

  br_funct3_e       w_f3;
  br_flags_t        w_flags;
  logic             w_taken;
  logic             w_eq;
  logic             w_lt_s;
  logic             w_lt_u;
  logic             w_accept;
  logic             w_upd;
  logic [XLEN-1:0]  w_redirect;

  assign in_ready_o = !flush_i && (!r_valid || out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o;

  assign w_eq   = in_rs1_i == in_rs2_i;
  assign w_lt_s = $signed(in_rs1_i) < $signed(in_rs2_i);
  assign w_lt_u = in_rs1_i < in_rs2_i;
  assign w_f3   = br_funct3_e'(in_funct3_i);

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      BEQ:     w_taken = w_eq;
      BNE:     w_taken = !w_eq;
      BLT:     w_taken = w_lt_s;
      BGE:     w_taken = !w_lt_s;
      BLTU:    w_taken = w_lt_u;
      BGEU:    w_taken = !w_lt_u;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_flags.illegal    = f3_illegal(in_funct3_i);
  assign w_flags.taken      = w_taken;
  assign w_flags.mispredict = !w_flags.illegal && (w_taken ^ in_pred_taken_i);

  // sums wrap naturally at XLEN bits
  assign w_redirect = w_taken ? (in_pc_i + in_imm_i) : (in_pc_i + XLEN'(4));
  assign w_upd      = w_accept && !w_flags.illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_flags    <= '0;
      r_redirect <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_flags    <= w_flags;
      r_redirect <= w_redirect;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_branches    <= '0;
      r_mispredicts <= '0;
    end else if (w_upd) begin
      r_branches <= r_branches + CNT_W'(1);
      if (w_flags.mispredict) r_mispredicts <= r_mispredicts + CNT_W'(1);
    end
  end

  bht_bimodal #(
    .XLEN      (XLEN),
    .BHT_DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_pc     (fetch_pc_i),
    .o_rd_taken  (fetch_pred_taken_o),
    .i_upd_en    (w_upd),
    .i_upd_pc    (in_pc_i),
    .i_upd_taken (w_taken)
  );

  assign out_valid_o        = r_valid;
  assign out_taken_o        = r_flags.taken;
  assign out_mispredict_o   = r_flags.mispredict;
  assign out_illegal_o      = r_flags.illegal;
  assign out_redirect_pc_o  = r_redirect;
  assign stat_branches_o    = r_branches;
  assign stat_mispredicts_o = r_mispredicts;

endmodule
